// File: rtl/axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_slave
//
// AXI4-Lite responder that terminates the host control path of the PairHMM
// accelerator. It holds a small register file (CTRL, STATUS, IRQ_EN and a
// bank of CFG words). Host writes are turned into a one-cycle engine start
// pulse and configuration outputs. Engine busy/done status is reported back
// to the host.
//
// Register map (32-bit words, byte addresses):
//   0x00 CTRL    bit0 write-1 -> start pulse, reads 0
//   0x04 STATUS  bit0 busy_i (sampled at AR), bit1 done_sticky (W1C)
//   0x08 IRQ_EN  bit0 read/write
//   0x0C..       CFG[0..NUM_REGS-4], full 32-bit read/write
//
// Ports:
//   clock, reset           single clock, synchronous active-high reset
//   s_aw*, s_w*, s_b*      AXI4-Lite write address / data / response
//   s_ar*, s_r*            AXI4-Lite read address / data
//   start_o                one-cycle start pulse to the engine
//   busy_i, done_i         engine busy level, engine done pulse
//   cfg_o                  concatenated CFG registers, CFG[0] in the LSBs
//   irq_o                  registered done_sticky AND IRQ_EN[0]
// ----------------------------------------------------------------------------
module axi_lite_reg_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        s_awaddr,
    input  logic                         s_awvalid,
    output logic                         s_awready,
    input  logic [31:0]                  s_wdata,
    input  logic [3:0]                   s_wstrb,
    input  logic                         s_wvalid,
    output logic                         s_wready,
    output logic [1:0]                   s_bresp,
    output logic                         s_bvalid,
    input  logic                         s_bready,
    input  logic [ADDR_WIDTH-1:0]        s_araddr,
    input  logic                         s_arvalid,
    output logic                         s_arready,
    output logic [31:0]                  s_rdata,
    output logic [1:0]                   s_rresp,
    output logic                         s_rvalid,
    input  logic                         s_rready,
    output logic                         start_o,
    input  logic                         busy_i,
    input  logic                         done_i,
    output logic [(NUM_REGS-3)*32-1:0]   cfg_o,
    output logic                         irq_o
);

    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int NUM_CFG  = NUM_REGS - 3;
    localparam int CFG_BASE = 3;
    localparam int WADDR_W  = ADDR_WIDTH - 2;

    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_IRQ_EN = IDX_W'(2);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A word address is in range only if nothing above the index field is set.
    function automatic logic word_in_range(input logic [WADDR_W-1:0] word_addr);
        return (word_addr >> IDX_W) == '0;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return result;
    endfunction

    // Byte-offset address bits carry no information for word registers.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    // Write channel state
    logic                aw_full_q, aw_full_d;
    logic [WADDR_W-1:0]  aw_addr_q, aw_addr_d;
    logic                w_full_q, w_full_d;
    logic [31:0]         w_data_q, w_data_d;
    logic [3:0]          w_strb_q, w_strb_d;
    logic                b_valid_q, b_valid_d;
    logic [1:0]          b_resp_q, b_resp_d;

    // Read channel state
    logic                r_valid_q, r_valid_d;
    logic [31:0]         r_data_q, r_data_d;
    logic [1:0]          r_resp_q, r_resp_d;

    // Register file
    logic                start_q, start_d;
    logic                done_sticky_q, done_sticky_d;
    logic                irq_en_q, irq_en_d;
    logic                irq_q, irq_d;
    logic [31:0]         cfg_q [NUM_CFG];
    logic [31:0]         cfg_d [NUM_CFG];

    logic                aw_fire, w_fire, ar_fire;
    logic                commit;
    logic                wr_ok;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic                rd_ok;
    logic [31:0]         rd_word;

    // Address and data each have a one-entry holding slot; neither slot
    // accepts new traffic until the write response has been consumed.
    assign s_awready = ~aw_full_q & ~b_valid_q;
    assign s_wready  = ~w_full_q  & ~b_valid_q;
    assign s_bvalid  = b_valid_q;
    assign s_bresp   = b_resp_q;
    assign s_arready = ~r_valid_q;
    assign s_rvalid  = r_valid_q;
    assign s_rdata   = r_data_q;
    assign s_rresp   = r_resp_q;
    assign start_o   = start_q;
    assign irq_o     = irq_q;

    assign aw_fire = s_awvalid & s_awready;
    assign w_fire  = s_wvalid  & s_wready;
    assign ar_fire = s_arvalid & s_arready;
    assign commit  = aw_full_q & w_full_q;
    assign wr_idx  = aw_addr_q[IDX_W-1:0];
    assign wr_ok   = word_in_range(aw_addr_q);
    assign rd_idx  = s_araddr[IDX_W+1:2];
    assign rd_ok   = word_in_range(s_araddr[ADDR_WIDTH-1:2]);

    // Write handshakes fill the address/data slots independently; once both
    // are full the write commits and the response is raised in the same edge.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        if (aw_fire) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_fire) begin
            w_full_d = 1'b1;
            w_data_d = s_wdata;
            w_strb_d = s_wstrb;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
        if (b_valid_q && s_bready) begin
            b_valid_d = 1'b0;
        end
    end

    // Register updates on commit. A done pulse is applied after the W1C so
    // that a simultaneous done and clear leaves the sticky bit set.
    always_comb begin
        start_d       = 1'b0;
        done_sticky_d = done_sticky_q;
        irq_en_d      = irq_en_q;
        cfg_d         = cfg_q;
        if (commit && wr_ok) begin
            if (wr_idx == IDX_CTRL) begin
                start_d = w_strb_q[0] & w_data_q[0];
            end
            if (wr_idx == IDX_STATUS && w_strb_q[0] && w_data_q[1]) begin
                done_sticky_d = 1'b0;
            end
            if (wr_idx == IDX_IRQ_EN && w_strb_q[0]) begin
                irq_en_d = w_data_q[0];
            end
            for (int i = 0; i < NUM_CFG; i++) begin
                if (wr_idx == IDX_W'(CFG_BASE + i)) begin
                    cfg_d[i] = merge_bytes(cfg_q[i], w_data_q, w_strb_q);
                end
            end
        end
        if (done_i) begin
            done_sticky_d = 1'b1;
        end
        irq_d = done_sticky_q & irq_en_q;
    end

    // Read-side register decode, evaluated against the live register state
    // and busy_i so the value captured at the AR handshake is current.
    always_comb begin
        rd_word = '0;
        if (rd_idx == IDX_STATUS) begin
            rd_word = {30'd0, done_sticky_q, busy_i};
        end
        if (rd_idx == IDX_IRQ_EN) begin
            rd_word = {31'd0, irq_en_q};
        end
        for (int i = 0; i < NUM_CFG; i++) begin
            if (rd_idx == IDX_W'(CFG_BASE + i)) begin
                rd_word = cfg_q[i];
            end
        end
    end

    // Read channel: capture data at the AR handshake, hold it until R completes.
    always_comb begin
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        if (r_valid_q && s_rready) begin
            r_valid_d = 1'b0;
        end
        if (ar_fire) begin
            r_valid_d = 1'b1;
            r_data_d  = rd_ok ? rd_word : 32'd0;
            r_resp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // CFG bank flattened onto the output bus, CFG[0] in the LSBs.
    always_comb begin
        cfg_o = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            cfg_o[i*32 +: 32] = cfg_q[i];
        end
    end

    // State registers; reset abandons any in-flight transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            aw_full_q     <= 1'b0;
            aw_addr_q     <= '0;
            w_full_q      <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            b_valid_q     <= 1'b0;
            b_resp_q      <= RESP_OKAY;
            r_valid_q     <= 1'b0;
            r_data_q      <= '0;
            r_resp_q      <= RESP_OKAY;
            start_q       <= 1'b0;
            done_sticky_q <= 1'b0;
            irq_en_q      <= 1'b0;
            irq_q         <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_q[i] <= '0;
            end
        end else begin
            aw_full_q     <= aw_full_d;
            aw_addr_q     <= aw_addr_d;
            w_full_q      <= w_full_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            b_valid_q     <= b_valid_d;
            b_resp_q      <= b_resp_d;
            r_valid_q     <= r_valid_d;
            r_data_q      <= r_data_d;
            r_resp_q      <= r_resp_d;
            start_q       <= start_d;
            done_sticky_q <= done_sticky_d;
            irq_en_q      <= irq_en_d;
            irq_q         <= irq_d;
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_q[i] <= cfg_d[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_reg_slave
//
// Self-checking bench for axi_lite_reg_slave. A behavioural register model
// (arrays and flags) predicts read data, responses, cfg_o, irq_o and start
// pulses for directed scenarios followed by randomized traffic.
// ----------------------------------------------------------------------------
module tb_axi_lite_reg_slave;

    localparam int ADDR_WIDTH = 32;
    localparam int NUM_REGS   = 8;
    localparam int NUM_CFG    = NUM_REGS - 3;

    logic                       clock = 1'b0;
    logic                       reset;
    logic [ADDR_WIDTH-1:0]      s_awaddr;
    logic                       s_awvalid;
    logic                       s_awready;
    logic [31:0]                s_wdata;
    logic [3:0]                 s_wstrb;
    logic                       s_wvalid;
    logic                       s_wready;
    logic [1:0]                 s_bresp;
    logic                       s_bvalid;
    logic                       s_bready;
    logic [ADDR_WIDTH-1:0]      s_araddr;
    logic                       s_arvalid;
    logic                       s_arready;
    logic [31:0]                s_rdata;
    logic [1:0]                 s_rresp;
    logic                       s_rvalid;
    logic                       s_rready;
    logic                       start_o;
    logic                       busy_i;
    logic                       done_i;
    logic [NUM_CFG*32-1:0]      cfg_o;
    logic                       irq_o;

    int num_checks = 0;
    int num_fail   = 0;
    int start_count = 0;

    // Behavioural model of the register file
    logic [31:0] model_cfg [NUM_CFG];
    logic        model_sticky;
    logic        model_irq_en;

    always #5 clock = ~clock;

    axi_lite_reg_slave #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .start_o   (start_o),
        .busy_i    (busy_i),
        .done_i    (done_i),
        .cfg_o     (cfg_o),
        .irq_o     (irq_o)
    );

    // Count every cycle in which the start pulse is observed high.
    always @(negedge clock) begin
        if (start_o === 1'b1) start_count++;
    end

    // Hard time limit so the bench never hangs.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic bit addrInRange(input logic [31:0] addr);
        return addr < 32'(NUM_REGS * 4);
    endfunction

    function automatic logic [31:0] expReadData(input logic [31:0] addr, input logic busy);
        int idx;
        if (!addrInRange(addr)) return 32'd0;
        idx = int'(addr >> 2);
        case (idx)
            0:       return 32'd0;
            1:       return {30'd0, model_sticky, busy};
            2:       return {31'd0, model_irq_en};
            default: return model_cfg[idx-3];
        endcase
    endfunction

    task automatic modelReset();
        model_sticky = 1'b0;
        model_irq_en = 1'b0;
        for (int i = 0; i < NUM_CFG; i++) model_cfg[i] = 32'd0;
    endtask

    task automatic checkCfgAndIrq(input string tag);
        for (int i = 0; i < NUM_CFG; i++) begin
            checkOutput({tag, "_cfg_o"}, cfg_o[i*32 +: 32], model_cfg[i]);
        end
        checkOutput({tag, "_irq_o"}, 32'(irq_o), 32'(model_sticky & model_irq_en));
    endtask

    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_delay,
                            input int w_delay, input int b_delay,
                            input bit done_at_commit);
        bit         aw_done, w_done, aw_fire, w_fire, in_range, exp_start;
        int         cyc, idx, start_before;
        logic [1:0] exp_resp;
        in_range     = addrInRange(addr);
        idx          = int'(addr >> 2);
        exp_resp     = in_range ? 2'b00 : 2'b10;
        exp_start    = in_range && idx == 0 && strb[0] && data[0];
        start_before = start_count;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clock);
            s_awaddr  = addr;
            s_wdata   = data;
            s_wstrb   = strb;
            s_awvalid = !aw_done && cyc >= aw_delay;
            s_wvalid  = !w_done && cyc >= w_delay;
            aw_fire   = s_awvalid && s_awready;
            w_fire    = s_wvalid && s_wready;
            @(posedge clock); #1;
            aw_done |= aw_fire;
            w_done  |= w_fire;
            cyc++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            checkOutput("wr_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        done_i = done_at_commit;
        @(negedge clock);
        checkOutput("bvalid_not_early", 32'(s_bvalid), 32'd0);
        @(posedge clock); #1;
        done_i = 1'b0;
        if (in_range) begin
            if (idx == 1 && strb[0] && data[1]) model_sticky = 1'b0;
            if (idx == 2 && strb[0]) model_irq_en = data[0];
            if (idx >= 3) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model_cfg[idx-3][b*8 +: 8] = data[b*8 +: 8];
                end
            end
        end
        if (done_at_commit) model_sticky = 1'b1;
        @(negedge clock);
        checkOutput("bvalid", 32'(s_bvalid), 32'd1);
        checkOutput("bresp", 32'(s_bresp), 32'(exp_resp));
        checkOutput("start_o_at_b", 32'(start_o), 32'(exp_start));
        for (int k = 0; k < b_delay; k++) begin
            @(negedge clock);
            checkOutput("bvalid_hold", 32'(s_bvalid), 32'd1);
            checkOutput("bresp_hold", 32'(s_bresp), 32'(exp_resp));
            checkOutput("awready_blocked", 32'(s_awready), 32'd0);
            checkOutput("wready_blocked", 32'(s_wready), 32'd0);
        end
        s_bready = 1'b1;
        @(posedge clock); #1;
        s_bready = 1'b0;
        @(negedge clock);
        checkOutput("bvalid_cleared", 32'(s_bvalid), 32'd0);
        checkOutput("awready_after_b", 32'(s_awready), 32'd1);
        checkOutput("wready_after_b", 32'(s_wready), 32'd1);
        checkCfgAndIrq("wr");
        #1;
        checkOutput("start_pulse_count", 32'(start_count - start_before), 32'(exp_start));
    endtask

    task automatic axiRead(input logic [31:0] addr, input int ar_delay, input int r_delay);
        bit          fire;
        int          cyc;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        repeat (ar_delay) @(negedge clock);
        fire = 0; cyc = 0;
        exp_data = 32'd0;
        exp_resp = 2'b00;
        while (!fire && cyc < 40) begin
            @(negedge clock);
            s_araddr  = addr;
            s_arvalid = 1'b1;
            fire      = s_arready;
            if (fire) begin
                exp_data = expReadData(addr, busy_i);
                exp_resp = addrInRange(addr) ? 2'b00 : 2'b10;
            end
            @(posedge clock); #1;
            cyc++;
        end
        s_arvalid = 1'b0;
        if (!fire) begin
            checkOutput("rd_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        @(negedge clock);
        checkOutput("rvalid", 32'(s_rvalid), 32'd1);
        checkOutput("rdata", s_rdata, exp_data);
        checkOutput("rresp", 32'(s_rresp), 32'(exp_resp));
        checkOutput("arready_blocked", 32'(s_arready), 32'd0);
        for (int k = 0; k < r_delay; k++) begin
            @(negedge clock);
            checkOutput("rvalid_hold", 32'(s_rvalid), 32'd1);
            checkOutput("rdata_hold", s_rdata, exp_data);
        end
        s_rready = 1'b1;
        @(posedge clock); #1;
        s_rready = 1'b0;
        @(negedge clock);
        checkOutput("rvalid_cleared", 32'(s_rvalid), 32'd0);
        checkOutput("arready_after_r", 32'(s_arready), 32'd1);
    endtask

    task automatic pulseDone();
        @(negedge clock);
        done_i = 1'b1;
        @(posedge clock); #1;
        done_i = 1'b0;
        model_sticky = 1'b1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_awready"}, 32'(s_awready), 32'd1);
        checkOutput({tag, "_wready"}, 32'(s_wready), 32'd1);
        checkOutput({tag, "_arready"}, 32'(s_arready), 32'd1);
        checkOutput({tag, "_bvalid"}, 32'(s_bvalid), 32'd0);
        checkOutput({tag, "_rvalid"}, 32'(s_rvalid), 32'd0);
        checkOutput({tag, "_bresp"}, 32'(s_bresp), 32'd0);
        checkOutput({tag, "_rresp"}, 32'(s_rresp), 32'd0);
        checkOutput({tag, "_rdata"}, s_rdata, 32'd0);
        checkOutput({tag, "_start_o"}, 32'(start_o), 32'd0);
        checkOutput({tag, "_irq_o"}, 32'(irq_o), 32'd0);
        checkOutput({tag, "_cfg_o_lo"}, cfg_o[31:0], 32'd0);
    endtask

    // Randomized mix of reads, writes and done pulses over the whole map,
    // including ignored low address bits and out-of-range addresses.
    task automatic applyStimulus(input int num_txn);
        logic [31:0] addr;
        int          pick;
        for (int n = 0; n < num_txn; n++) begin
            busy_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) pulseDone();
            pick = $urandom_range(0, 9);
            if (pick < NUM_REGS) addr = 32'(pick * 4 + $urandom_range(0, 3));
            else                 addr = $urandom | 32'h0000_0020;
            if ($urandom_range(0, 1) == 0) begin
                axiWrite(addr, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 7) == 0);
            end else begin
                axiRead(addr, $urandom_range(0, 2), $urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        busy_i    = 1'b0;
        done_i    = 1'b0;
        modelReset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkResetValues("reset");

        // CFG[0] with W arriving two cycles after AW
        axiWrite(32'h0000_000C, 32'hDEAD_BEEF, 4'hF, 0, 2, 0, 1'b0);
        checkOutput("cfg0_deadbeef", cfg_o[31:0], 32'hDEAD_BEEF);
        axiRead(32'h0000_000C, 0, 0);

        // Partial strobe merge over an all-ones CFG[1]
        axiWrite(32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 1'b0);
        axiWrite(32'h0000_0010, 32'h1122_3344, 4'h5, 0, 0, 1, 1'b0);
        checkOutput("cfg1_strobe_merge", cfg_o[63:32], 32'hFF22_FF44);
        axiRead(32'h0000_0010, 1, 2);

        // Start pulse and CTRL readback
        axiWrite(32'h0000_0000, 32'h0000_0001, 4'hF, 1, 0, 0, 1'b0);
        axiRead(32'h0000_0000, 0, 0);

        // Done sticky, interrupt timing and W1C
        axiWrite(32'h0000_0008, 32'h0000_0001, 4'hF, 0, 0, 0, 1'b0);
        pulseDone();
        @(negedge clock);
        checkOutput("irq_not_yet", 32'(irq_o), 32'd0);
        @(negedge clock);
        checkOutput("irq_set", 32'(irq_o), 32'd1);
        axiRead(32'h0000_0004, 0, 0);
        axiWrite(32'h0000_0004, 32'h0000_0002, 4'hF, 0, 0, 0, 1'b0);
        axiRead(32'h0000_0004, 0, 0);
        checkOutput("irq_cleared", 32'(irq_o), 32'd0);
        pulseDone();
        axiWrite(32'h0000_0004, 32'h0000_0002, 4'hF, 0, 0, 0, 1'b1);
        axiRead(32'h0000_0004, 0, 0);
        checkOutput("irq_set_wins", 32'(irq_o), 32'd1);

        // Out-of-range access
        axiWrite(32'h0000_0100, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 1'b0);
        axiRead(32'h0000_0100, 0, 0);

        // Response held while bready stays low
        axiWrite(32'h0000_0014, 32'h0BAD_F00D, 4'hF, 0, 1, 5, 1'b0);

        // Reset with a pending R and a half-latched write
        @(negedge clock);
        s_araddr  = 32'h0000_000C;
        s_arvalid = 1'b1;
        s_awaddr  = 32'h0000_0018;
        s_awvalid = 1'b1;
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        @(negedge clock);
        checkOutput("rvalid_pending", 32'(s_rvalid), 32'd1);
        checkOutput("awready_half_write", 32'(s_awready), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b0;
        modelReset();
        checkResetValues("midreset");
        @(negedge clock);
        checkOutput("no_b_after_reset", 32'(s_bvalid), 32'd0);
        checkCfgAndIrq("post_reset");

        applyStimulus(60);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
